// File: rtl/seguridad_pkg.sv
`default_nettype none
// ============================================================================
// Package     : seguridad_pkg
// Description : Shared types and constants for the security keypad controller
//               (state encoding, digit width, default stored code).
// Revision    : 1.0 - initial release
// ============================================================================
package seguridad_pkg;

    localparam int          ANCHO_DIGITO  = 4;
    localparam int          NUM_TECLAS    = 10;
    localparam logic [15:0] CLAVE_DEFECTO = 16'h4321;

    typedef enum logic [2:0] {
        ESPERA   = 3'd0,
        VERIFICA = 3'd1,
        ABIERTO  = 3'd2,
        FALLO    = 3'd3,
        ALARMA   = 3'd4
    } estado_t;

    // Larger of two integers, used to size the timer shared by two states
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/control_acceso_if.sv
`default_nettype none
// ============================================================================
// Interface   : control_acceso_if
// Description : Keypad inputs and door/alarm outputs of the access controller.
//               master = keypad/driver side, slave = controller side.
// Revision    : 1.0 - initial release
// ============================================================================
interface control_acceso_if;
    import seguridad_pkg::*;

    logic [NUM_TECLAS-1:0]   teclas;
    logic                    enter;
    logic                    verificacion;
    logic                    fallo;
    logic                    alarma;
    logic [1:0]              intentos;
    logic [ANCHO_DIGITO-1:0] digitos;

    modport master (
        output teclas, enter,
        input  verificacion, fallo, alarma, intentos, digitos
    );

    modport slave (
        input  teclas, enter,
        output verificacion, fallo, alarma, intentos, digitos
    );

endinterface
`default_nettype wire

// File: rtl/codificador_teclas.sv
`default_nettype none
// ============================================================================
// Module      : codificador_teclas
// Description : Registers the keypad inputs, detects rising edges and encodes
//               a single newly pressed digit. Multi-key events are discarded
//               and an enter edge suppresses a same-cycle digit.
// Revision    : 1.0 - initial release
// ============================================================================
module codificador_teclas
    import seguridad_pkg::*;
(
    input  wire                     clk,
    input  wire                     rst,
    input  wire [NUM_TECLAS-1:0]    teclas,
    input  wire                     enter,
    output logic                    digito_valido,
    output logic [ANCHO_DIGITO-1:0] digito,
    output logic                    enter_evt
);

    logic [NUM_TECLAS-1:0]   r_teclas_q;
    logic                    r_enter_q;
    logic                    r_digito_valido;
    logic [ANCHO_DIGITO-1:0] r_digito;
    logic [NUM_TECLAS-1:0]   w_flancos;
    logic                    w_un_flanco;
    logic                    w_enter_evt;
    logic [ANCHO_DIGITO-1:0] w_indice;

    assign w_flancos   = teclas & ~r_teclas_q;
    assign w_un_flanco = ($countones(w_flancos) == 1);
    assign w_enter_evt = enter & ~r_enter_q;

    // Binary index of the pressed key; only meaningful when exactly one edge
    always_comb begin
        w_indice = '0;
        for (int i = 0; i < NUM_TECLAS; i++) begin
            if (w_flancos[i]) begin
                w_indice = ANCHO_DIGITO'(i);
            end
        end
    end

    // Input registers plus the digit event stage; enter events are passed
    // through combinationally so the FSM reacts on the sampling edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_teclas_q      <= '0;
            r_enter_q       <= 1'b0;
            r_digito_valido <= 1'b0;
            r_digito        <= '0;
        end else begin
            r_teclas_q      <= teclas;
            r_enter_q       <= enter;
            r_digito_valido <= w_un_flanco && !w_enter_evt;
            r_digito        <= w_indice;
        end
    end

    assign digito_valido = r_digito_valido;
    assign digito        = r_digito;
    assign enter_evt     = w_enter_evt;

endmodule
`default_nettype wire

// File: rtl/control_acceso.sv
`default_nettype none
// ============================================================================
// Module      : control_acceso
// Description : Keypad code-entry sequencer. Collects BCD digits, verifies the
//               entry against the stored code, opens the door for a fixed time,
//               pulses a failure flag and locks out after repeated failures.
//               Config macro: BLOQUEO_TIMEOUT_EN (timed lockout release).
// Revision    : 1.0 - initial release
// ============================================================================
module control_acceso
    import seguridad_pkg::*;
#(
    parameter int                              NUM_DIGITOS    = 4,
    parameter logic [4*NUM_DIGITOS-1:0]        CLAVE          = CLAVE_DEFECTO,
    parameter int                              MAX_FALLOS     = 2,
    parameter int                              ABIERTO_CICLOS = 8,
    parameter int                              BLOQUEO_CICLOS = 16
) (
    input  wire              clk,
    input  wire              rst,
    control_acceso_if.slave  bus
);

    localparam int c_ancho_clave = ANCHO_DIGITO * NUM_DIGITOS;
    localparam int c_ancho_timer = $clog2(max_int(ABIERTO_CICLOS, BLOQUEO_CICLOS) + 1);

    localparam logic [ANCHO_DIGITO-1:0]  c_digitos_ok    = ANCHO_DIGITO'(NUM_DIGITOS);
    localparam logic [ANCHO_DIGITO-1:0]  c_digitos_max   = ANCHO_DIGITO'(NUM_DIGITOS + 1);
    localparam logic [ANCHO_DIGITO-1:0]  c_digitos_uno   = ANCHO_DIGITO'(1);
    localparam logic [1:0]               c_max_fallos    = 2'(MAX_FALLOS);
    localparam logic [c_ancho_timer-1:0] c_timer_abierto = c_ancho_timer'(ABIERTO_CICLOS - 1);
    localparam logic [c_ancho_timer-1:0] c_timer_uno     = c_ancho_timer'(1);
`ifdef BLOQUEO_TIMEOUT_EN
    localparam logic [c_ancho_timer-1:0] c_timer_bloqueo = c_ancho_timer'(BLOQUEO_CICLOS - 1);
`endif

    estado_t                 r_estado;
    estado_t                 w_estado_sig;
    logic [c_ancho_timer-1:0] r_timer;
    logic [c_ancho_timer-1:0] w_timer_sig;
    logic [c_ancho_clave-1:0] r_buffer;
    logic [c_ancho_clave-1:0] w_buffer_sig;
    logic [c_ancho_clave-1:0] w_buffer_desplazado;
    logic [ANCHO_DIGITO-1:0]  r_digitos;
    logic [ANCHO_DIGITO-1:0]  w_digitos_sig;
    logic [1:0]               r_intentos;
    logic [1:0]               w_intentos_sig;
    logic [1:0]               w_intentos_inc;
    logic                     w_coincide;

    logic                     w_digito_valido;
    logic [ANCHO_DIGITO-1:0]  w_digito;
    logic                     w_enter_evt;

    codificador_teclas u_codificador (
        .clk           (clk),
        .rst           (rst),
        .teclas        (bus.teclas),
        .enter         (bus.enter),
        .digito_valido (w_digito_valido),
        .digito        (w_digito),
        .enter_evt     (w_enter_evt)
    );

    // New digit enters the low nibble; older digits move up
    generate
        if (NUM_DIGITOS == 1) begin : g_buffer_un_digito
            assign w_buffer_desplazado = w_digito;
        end else begin : g_buffer_varios_digitos
            assign w_buffer_desplazado = {r_buffer[c_ancho_clave-ANCHO_DIGITO-1:0], w_digito};
        end
    endgenerate

    // Over-length entries saturate above NUM_DIGITOS and can never match
    assign w_coincide     = (r_digitos == c_digitos_ok) && (r_buffer == CLAVE);
    assign w_intentos_inc = r_intentos + 2'd1;

    // Next-state, timer, buffer and failure-count logic
    always_comb begin
        w_estado_sig   = r_estado;
        w_timer_sig    = r_timer;
        w_buffer_sig   = r_buffer;
        w_digitos_sig  = r_digitos;
        w_intentos_sig = r_intentos;

        case (r_estado)
            ESPERA: begin
                // Enter has priority over a digit arriving in the same cycle
                if (w_enter_evt) begin
                    w_estado_sig = VERIFICA;
                end else if (w_digito_valido) begin
                    w_buffer_sig = w_buffer_desplazado;
                    if (r_digitos != c_digitos_max) begin
                        w_digitos_sig = r_digitos + c_digitos_uno;
                    end
                end
            end

            VERIFICA: begin
                w_buffer_sig  = '0;
                w_digitos_sig = '0;
                if (w_coincide) begin
                    w_estado_sig   = ABIERTO;
                    w_intentos_sig = '0;
                    w_timer_sig    = c_timer_abierto;
                end else begin
                    w_intentos_sig = w_intentos_inc;
                    if (w_intentos_inc == c_max_fallos) begin
                        w_estado_sig = ALARMA;
`ifdef BLOQUEO_TIMEOUT_EN
                        w_timer_sig  = c_timer_bloqueo;
`endif
                    end else begin
                        w_estado_sig = FALLO;
                    end
                end
            end

            ABIERTO: begin
                if (r_timer == '0) begin
                    w_estado_sig = ESPERA;
                end else begin
                    w_timer_sig = r_timer - c_timer_uno;
                end
            end

            FALLO: begin
                w_estado_sig = ESPERA;
            end

            ALARMA: begin
`ifdef BLOQUEO_TIMEOUT_EN
                if (r_timer == '0) begin
                    w_estado_sig   = ESPERA;
                    w_intentos_sig = '0;
                end else begin
                    w_timer_sig = r_timer - c_timer_uno;
                end
`else
                // Lockout only clears through reset
                w_estado_sig = ALARMA;
`endif
            end

            default: begin
                w_estado_sig = ESPERA;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_estado   <= ESPERA;
            r_timer    <= '0;
            r_buffer   <= '0;
            r_digitos  <= '0;
            r_intentos <= '0;
        end else begin
            r_estado   <= w_estado_sig;
            r_timer    <= w_timer_sig;
            r_buffer   <= w_buffer_sig;
            r_digitos  <= w_digitos_sig;
            r_intentos <= w_intentos_sig;
        end
    end

    assign bus.verificacion = (r_estado == ABIERTO);
    assign bus.fallo        = (r_estado == FALLO);
    assign bus.alarma       = (r_estado == ALARMA);
    assign bus.intentos     = r_intentos;
    assign bus.digitos      = r_digitos;

endmodule
`default_nettype wire

// File: tb/tb_control_acceso.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_acceso
// Description : Self-checking bench for control_acceso: a vector table, directed
//               sequences and randomized keypad activity checked against a
//               behavioural model. Honours BLOQUEO_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_acceso;

    localparam int          ND       = 4;
    localparam logic [15:0] CLAVE_TB = 16'h4321;
    localparam int          MAXF     = 2;
    localparam int          ABIERTO  = 8;
    localparam int          BLOQUEO  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    control_acceso_if bus ();

    control_acceso #(
        .NUM_DIGITOS    (ND),
        .CLAVE          (CLAVE_TB),
        .MAX_FALLOS     (MAXF),
        .ABIERTO_CICLOS (ABIERTO),
        .BLOQUEO_CICLOS (BLOQUEO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errores = 0;
    int checks  = 0;

    // ---------------- behavioural model ----------------
    int         m_q[$];        // digits of the current entry, in press order
    logic [9:0] m_prev_t;
    bit         m_prev_e;
    int         m_pend;        // digit waiting one cycle before it counts, -1 none
    bit         m_verif_pend;  // an entry is being judged this cycle
    int         m_open;        // remaining cycles of granted access
    bit         m_fail;
    bit         m_locked;
    int         m_lock_left;
    int         m_fails;

    task automatic modelo_reset();
        m_q.delete();
        m_prev_t = '0; m_prev_e = 0; m_pend = -1; m_verif_pend = 0;
        m_open = 0; m_fail = 0; m_locked = 0; m_lock_left = 0; m_fails = 0;
    endtask

    task automatic modelo_paso(input logic [9:0] t, input logic e);
        logic [9:0] flancos;
        bit         ev_enter;
        int         nuevo;
        int         valor;
        bit         ok;
        flancos  = t & ~m_prev_t;
        ev_enter = e && !m_prev_e;
        nuevo    = -1;
        if ($countones(flancos) == 1 && !ev_enter)
            for (int i = 0; i < 10; i++) if (flancos[i]) nuevo = i;

        if (m_verif_pend) begin
            valor = 0;
            foreach (m_q[k]) valor = valor * 16 + m_q[k];
            ok = (m_q.size() == ND) && (valor == int'(CLAVE_TB));
            m_q.delete();
            m_verif_pend = 0;
            if (ok) begin
                m_fails = 0;
                m_open  = ABIERTO;
            end else begin
                m_fails++;
                if (m_fails == MAXF) begin
                    m_locked    = 1;
                    m_lock_left = BLOQUEO;
                end else begin
                    m_fail = 1;
                end
            end
        end else if (m_open > 0) begin
            m_open--;
        end else if (m_fail) begin
            m_fail = 0;
        end else if (m_locked) begin
`ifdef BLOQUEO_TIMEOUT_EN
            m_lock_left--;
            if (m_lock_left == 0) begin
                m_locked = 0;
                m_fails  = 0;
            end
`endif
        end else begin
            if (ev_enter) m_verif_pend = 1;
            else if (m_pend >= 0) m_q.push_back(m_pend);
        end
        m_pend   = nuevo;
        m_prev_t = t;
        m_prev_e = e;
    endtask

    // ---------------- checking ----------------
    task automatic comprobar(input string nombre, input int actual, input int esperado);
        checks++;
        if (actual !== esperado) begin
            errores++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nombre, actual, esperado, $time);
        end
    endtask

    task automatic compara_modelo();
        int d;
        d = (m_q.size() > ND) ? ND + 1 : m_q.size();
        comprobar("verificacion", int'(bus.verificacion), int'(m_open > 0));
        comprobar("fallo",        int'(bus.fallo),        int'(m_fail));
        comprobar("alarma",       int'(bus.alarma),       int'(m_locked));
        comprobar("intentos",     int'(bus.intentos),     m_fails);
        comprobar("digitos",      int'(bus.digitos),      d);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic ciclo(input logic [9:0] t, input logic e);
        bus.teclas = t;
        bus.enter  = e;
        @(posedge clk);
        modelo_paso(t, e);
        @(negedge clk);
        compara_modelo();
    endtask

    task automatic reiniciar();
        bus.teclas = '0;
        bus.enter  = 1'b0;
        #2 rst = 1'b0;
        #1;
        modelo_reset();
        compara_modelo();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic introducir(input int n, input logic [31:0] codigo, input bit aleatorio);
        int         h;
        int         g;
        logic [3:0] d;
        for (int k = 0; k < n; k++) begin
            d = codigo[(n-1-k)*4 +: 4];
            h = aleatorio ? int'($urandom_range(1, 3)) : 2;
            g = aleatorio ? int'($urandom_range(1, 3)) : 2;
            repeat (h) ciclo(10'd1 << d, 1'b0);
            repeat (g) ciclo('0, 1'b0);
        end
    endtask

    task automatic pulsar_enter(input int hold, input int idle);
        repeat (hold) ciclo('0, 1'b1);
        repeat (idle) ciclo('0, 1'b0);
    endtask

    typedef struct {
        logic [9:0] t;
        logic       e;
        logic       v;
        logic       f;
        logic       a;
        logic [1:0] n;
        logic [3:0] d;
    } vec_t;

    vec_t tabla [10];

    initial begin
        int         n;
        int         tipo;
        int         a;
        int         b;
        logic [31:0] codigo;
        int         len;

        // Keys 3 and 5 together, enter, then a single valid digit
        tabla[0] = '{10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0};
        tabla[1] = '{10'h028, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0};
        tabla[2] = '{10'h028, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0};
        tabla[3] = '{10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0};
        tabla[4] = '{10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0};
        tabla[5] = '{10'h000, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 4'd0};
        tabla[6] = '{10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 4'd0};
        tabla[7] = '{10'h080, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 4'd0};
        tabla[8] = '{10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 4'd1};
        tabla[9] = '{10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 4'd1};

        bus.teclas = '0;
        bus.enter  = 1'b0;
        reiniciar();

        // Vector table
        for (int i = 0; i < 10; i++) begin
            ciclo(tabla[i].t, tabla[i].e);
            comprobar($sformatf("tabla%0d_verificacion", i), int'(bus.verificacion), int'(tabla[i].v));
            comprobar($sformatf("tabla%0d_fallo", i),        int'(bus.fallo),        int'(tabla[i].f));
            comprobar($sformatf("tabla%0d_alarma", i),       int'(bus.alarma),       int'(tabla[i].a));
            comprobar($sformatf("tabla%0d_intentos", i),     int'(bus.intentos),     int'(tabla[i].n));
            comprobar($sformatf("tabla%0d_digitos", i),      int'(bus.digitos),      int'(tabla[i].d));
        end

        // Correct code: latency and open duration
        reiniciar();
        introducir(4, 32'h4321, 0);
        comprobar("digitos_antes_enter", int'(bus.digitos), 4);
        ciclo('0, 1'b1);
        comprobar("latencia_verifica", int'(bus.verificacion), 0);
        ciclo('0, 1'b1);
        comprobar("verificacion_inicio", int'(bus.verificacion), 1);
        n = int'(bus.verificacion);
        repeat (12) begin
            ciclo('0, 1'b0);
            n += int'(bus.verificacion);
        end
        comprobar("abierto_ciclos", n, ABIERTO);
        comprobar("intentos_tras_acierto", int'(bus.intentos), 0);

        // Wrong code then correct code
        introducir(4, 32'h7231, 0);
        ciclo('0, 1'b1);
        ciclo('0, 1'b1);
        comprobar("fallo_pulso", int'(bus.fallo), 1);
        comprobar("intentos_uno", int'(bus.intentos), 1);
        ciclo('0, 1'b0);
        comprobar("fallo_un_ciclo", int'(bus.fallo), 0);
        ciclo('0, 1'b0);
        introducir(4, 32'h4321, 0);
        ciclo('0, 1'b1);
        ciclo('0, 1'b1);
        comprobar("acierto_tras_fallo", int'(bus.verificacion), 1);
        comprobar("intentos_vuelve_cero", int'(bus.intentos), 0);
        repeat (10) ciclo('0, 1'b0);

        // Over-length entry, then a second failure locks out
        introducir(5, 32'h72312, 0);
        pulsar_enter(2, 2);
        comprobar("intentos_sobrelongitud", int'(bus.intentos), 1);
        introducir(4, 32'h2222, 0);
        ciclo('0, 1'b1);
        ciclo('0, 1'b1);
        comprobar("alarma_activa", int'(bus.alarma), 1);
        comprobar("intentos_alarma", int'(bus.intentos), MAXF);
        n = int'(bus.alarma);
`ifdef BLOQUEO_TIMEOUT_EN
        repeat (30) begin
            ciclo('0, 1'b0);
            n += int'(bus.alarma);
        end
        comprobar("alarma_ciclos", n, BLOQUEO);
        comprobar("intentos_tras_bloqueo", int'(bus.intentos), 0);
        introducir(4, 32'h4321, 0);
        ciclo('0, 1'b1);
        ciclo('0, 1'b1);
        comprobar("acierto_tras_bloqueo", int'(bus.verificacion), 1);
        repeat (10) ciclo('0, 1'b0);
`else
        repeat (99) begin
            ciclo('0, 1'b0);
            n += int'(bus.alarma);
        end
        comprobar("alarma_permanente", n, 100);
        introducir(4, 32'h4321, 0);
        ciclo('0, 1'b1);
        ciclo('0, 1'b1);
        comprobar("clave_ignorada_verif", int'(bus.verificacion), 0);
        comprobar("clave_ignorada_alarma", int'(bus.alarma), 1);
        reiniciar();
        comprobar("alarma_tras_reset", int'(bus.alarma), 0);
`endif

        // Reset in the middle of the open window
        reiniciar();
        introducir(4, 32'h4321, 0);
        pulsar_enter(2, 2);
        comprobar("abierto_antes_reset", int'(bus.verificacion), 1);
        bus.teclas = '0;
        bus.enter  = 1'b0;
        #2 rst = 1'b0;
        #1;
        comprobar("verificacion_reset_async", int'(bus.verificacion), 0);
        modelo_reset();
        compara_modelo();
        @(negedge clk);
        rst = 1'b1;
        introducir(4, 32'h4321, 0);
        pulsar_enter(1, 10);

        // Randomized keypad activity against the model
        for (int it = 0; it < 40; it++) begin
            if (m_locked) reiniciar();
            tipo = int'($urandom_range(0, 3));
            case (tipo)
                0: introducir(4, 32'h4321, 1);
                1, 2: begin
                    if (tipo == 2) begin
                        a = int'($urandom_range(0, 9));
                        b = (a + int'($urandom_range(1, 9))) % 10;
                        ciclo((10'd1 << a) | (10'd1 << b), 1'b0);
                        ciclo('0, 1'b0);
                    end
                    len = int'($urandom_range(0, 6));
                    codigo = '0;
                    for (int k = 0; k < len; k++)
                        codigo = {codigo[27:0], 4'($urandom_range(0, 9))};
                    introducir(len, codigo, 1);
                end
                default: begin
                    repeat (8) begin
                        if ($urandom_range(0, 2) == 0)
                            ciclo(10'($urandom), ($urandom_range(0, 7) == 0));
                        else
                            ciclo(10'd1 << $urandom_range(0, 9), ($urandom_range(0, 7) == 0));
                    end
                end
            endcase
            repeat ($urandom_range(1, 3)) ciclo('0, 1'b1);
            repeat ($urandom_range(1, 12)) begin
                if ($urandom_range(0, 4) == 0) ciclo(10'd1 << $urandom_range(0, 9), 1'b0);
                else                           ciclo('0, 1'b0);
            end
        end

        repeat (4) ciclo('0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errores, checks);
        $finish;
    end

endmodule
`default_nettype wire
